// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus; one grant per transfer.
// Optional transfer timeout with DEADBEEF completion and bus_err pulse: define ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned TO_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_mem_valid,
    output logic        m0_mem_ready,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic [31:0] m0_mem_rdata,
    input  logic        m1_mem_valid,
    output logic        m1_mem_ready,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic [31:0] m1_mem_rdata,
    output logic        s_mem_valid,
    input  logic        s_mem_ready,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic [31:0] s_mem_rdata,
    output logic        bus_err
);

    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] TO_RDATA = 32'hDEAD_BEEF;

    if (TIMEOUT < 2 || (64'(1) << TO_WIDTH) < 64'(TIMEOUT)) begin : g_bad_cfg
        $error("mem_bus_arbiter: TIMEOUT must be >= 2 and fit in TO_WIDTH bits");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;

    logic sel_c;
    logic grant_c;
    logic req_c;
    logic to_fire_c;
    logic done_c;

    // Selected master's request; only meaningful while a grant is held
    always_comb begin
        sel_c   = (state_q == GNT1);
        grant_c = (state_q == GNT0) || (state_q == GNT1);
        req_c   = grant_c && (sel_c ? m1_mem_valid : m0_mem_valid);
    end

`ifdef ARB_TIMEOUT_EN
    logic [TO_WIDTH-1:0] cnt_q, cnt_d;

    // Expiry only when the slave has not answered in the same cycle
    always_comb begin
        to_fire_c = req_c && !s_mem_ready && (cnt_q == TO_WIDTH'(TIMEOUT - 1));
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!grant_c) begin
            cnt_d = '0;
        end else if (!done_c) begin
            cnt_d = cnt_q + TO_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        to_fire_c = 1'b0;
    end
`endif

    always_comb begin
        done_c = (req_c && s_mem_ready) || to_fire_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Arbitration: on a tie the master that was not served last wins
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0_mem_valid && m1_mem_valid) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_mem_valid) begin
                    state_d = GNT0;
                end else if (m1_mem_valid) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!req_c) begin
                    state_d = IDLE;
                end else if (done_c) begin
                    state_d = IDLE;
                    last_d  = sel_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_mem_valid  = 1'b0;
        s_mem_addr   = '0;
        s_mem_wdata  = '0;
        s_mem_wstrb  = '0;
        m0_mem_ready = 1'b0;
        m0_mem_rdata = '0;
        m1_mem_ready = 1'b0;
        m1_mem_rdata = '0;
        bus_err      = to_fire_c;
        if (grant_c) begin
            s_mem_valid = req_c && !to_fire_c;
            s_mem_addr  = sel_c ? m1_mem_addr  : m0_mem_addr;
            s_mem_wdata = sel_c ? m1_mem_wdata : m0_mem_wdata;
            s_mem_wstrb = sel_c ? m1_mem_wstrb : m0_mem_wstrb;
        end
        if (done_c) begin
            if (sel_c) begin
                m1_mem_ready = 1'b1;
                m1_mem_rdata = to_fire_c ? TO_RDATA : s_mem_rdata;
            end else begin
                m0_mem_ready = 1'b1;
                m0_mem_rdata = to_fire_c ? TO_RDATA : s_mem_rdata;
            end
        end
    end

endmodule
